calc_entry: RTL and testbench

CALC_ENTRY -- requirements
Module: calc_entry

---
 rtl/calc_pkg.sv | 53 +++++
 rtl/calc_alu.sv | 44 ++++
 rtl/calc_entry.sv | 189 ++++++++++++++++++
 tb/tb_calc_entry.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator entry block: key codes,
// operator and state encodings, digit limit and the digit-append helper.
package calc_pkg;

  localparam logic [4:0] KEY_ADD = 5'h10;
  localparam logic [4:0] KEY_MUL = 5'h11;
  localparam logic [4:0] KEY_AND = 5'h12;
  localparam logic [4:0] KEY_EXE = 5'h13;
  localparam logic [4:0] KEY_SUB = 5'h14;
  localparam logic [4:0] KEY_OR  = 5'h15;
  localparam logic [4:0] KEY_CE  = 5'h16;
  localparam logic [4:0] KEY_CLR = 5'h17;

  // Each operand accepts at most this many digits; extra digits are dropped.
  localparam logic [2:0] MAX_DIGITS = 3'd4;

  typedef enum logic [2:0] {
    OPC_ADD = 3'd0,
    OPC_SUB = 3'd1,
    OPC_MUL = 3'd2,
    OPC_AND = 3'd3,
    OPC_OR  = 3'd4
  } opcode_t;

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_OP  = 2'd1,
    S_B   = 2'd2,
    S_RES = 2'd3
  } state_t;

  // Map an operator key code onto the latched opcode.
  function automatic opcode_t key_opcode(input logic [4:0] key);
    case (key)
      KEY_SUB: return OPC_SUB;
      KEY_MUL: return OPC_MUL;
      KEY_AND: return OPC_AND;
      KEY_OR:  return OPC_OR;
      default: return OPC_ADD;
    endcase
  endfunction

  // Shift a new digit into an operand: base 10 in decimal mode, base 16 otherwise.
  function automatic logic [15:0] append_digit(input logic [15:0] operand,
                                               input logic [3:0]  digit,
                                               input logic        dec);
    logic [15:0] d16;
    d16 = {12'd0, digit};
    if (dec) return (operand * 16'd10) + d16;
    else     return {operand[11:0], digit};
  endfunction

endpackage

// File: rtl/calc_alu.sv
// Purely combinational 16-bit unsigned arithmetic unit with overflow flag.
module calc_alu
  import calc_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  opcode_t     opcode,
  output logic [15:0] result,
  output logic        overflow
);

  logic [16:0] sum;
  logic [31:0] prod;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign prod = {16'd0, a} * {16'd0, b};

  // Select the operation; overflow is carry, borrow or a nonzero upper product half.
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (opcode)
      OPC_ADD: begin
        result   = sum[15:0];
        overflow = sum[16];
      end
      OPC_SUB: begin
        result   = a - b;
        overflow = (a < b);
      end
      OPC_MUL: begin
        result   = prod[15:0];
        overflow = |prod[31:16];
      end
      OPC_AND: result = a & b;
      OPC_OR:  result = a | b;
      default: begin
        result   = '0;
        overflow = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/calc_entry.sv
// Calculator key-entry controller: collects two operands and an operator from
// key strobes, runs the ALU on EXE and supports result chaining, CE and CLR.
module calc_entry
  import calc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [4:0]  val,
  input  logic        dec_mode,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic [2:0]  opcode,
  output logic [15:0] display,
  output logic [15:0] result,
  output logic        result_valid,
  output logic        overflow,
  output logic [1:0]  state
);

  state_t      state_reg, state_next;
  logic [15:0] op_a_reg, op_a_next;
  logic [15:0] op_b_reg, op_b_next;
  opcode_t     opcode_reg, opcode_next;
  logic [15:0] result_reg, result_next;
  logic        overflow_reg, overflow_next;
  logic        result_valid_reg, result_valid_next;
  logic [2:0]  cnt_a_reg, cnt_a_next;
  logic [2:0]  cnt_b_reg, cnt_b_next;

  logic [15:0] alu_result;
  logic        alu_overflow;
  logic        digit_ok;
  logic        do_clear;

  calc_alu u_alu (
    .a        (op_a_reg),
    .b        (op_b_reg),
    .opcode   (opcode_reg),
    .result   (alu_result),
    .overflow (alu_overflow)
  );

  // Digits A-F are not valid keys while in decimal entry.
  assign digit_ok = !val[4] && !(dec_mode && (val[3:0] > 4'd9));

  // Register all entry state; reset wins over any simultaneous key.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= S_A;
      op_a_reg         <= '0;
      op_b_reg         <= '0;
      opcode_reg       <= OPC_ADD;
      result_reg       <= '0;
      overflow_reg     <= 1'b0;
      result_valid_reg <= 1'b0;
      cnt_a_reg        <= '0;
      cnt_b_reg        <= '0;
    end else begin
      state_reg        <= state_next;
      op_a_reg         <= op_a_next;
      op_b_reg         <= op_b_next;
      opcode_reg       <= opcode_next;
      result_reg       <= result_next;
      overflow_reg     <= overflow_next;
      result_valid_reg <= result_valid_next;
      cnt_a_reg        <= cnt_a_next;
      cnt_b_reg        <= cnt_b_next;
    end
  end

  // Decode the accepted key against the current state into next-state values.
  always_comb begin
    state_next        = state_reg;
    op_a_next         = op_a_reg;
    op_b_next         = op_b_reg;
    opcode_next       = opcode_reg;
    result_next       = result_reg;
    overflow_next     = overflow_reg;
    result_valid_next = 1'b0;
    cnt_a_next        = cnt_a_reg;
    cnt_b_next        = cnt_b_reg;
    do_clear          = 1'b0;

    if (sel) begin
      if (!val[4]) begin
        if (digit_ok) begin
          case (state_reg)
            S_A: begin
              if (cnt_a_reg < MAX_DIGITS) begin
                op_a_next  = append_digit(op_a_reg, val[3:0], dec_mode);
                cnt_a_next = cnt_a_reg + 3'd1;
              end
            end
            S_OP: begin
              op_b_next  = {12'd0, val[3:0]};
              cnt_b_next = 3'd1;
              state_next = S_B;
            end
            S_B: begin
              if (cnt_b_reg < MAX_DIGITS) begin
                op_b_next  = append_digit(op_b_reg, val[3:0], dec_mode);
                cnt_b_next = cnt_b_reg + 3'd1;
              end
            end
            default: begin // S_RES: a digit starts a fresh calculation
              op_a_next  = {12'd0, val[3:0]};
              cnt_a_next = 3'd1;
              op_b_next  = '0;
              cnt_b_next = '0;
              state_next = S_A;
            end
          endcase
        end
      end else begin
        case (val)
          KEY_ADD, KEY_SUB, KEY_MUL, KEY_AND, KEY_OR: begin
            case (state_reg)
              S_A, S_OP: begin
                opcode_next = key_opcode(val);
                state_next  = S_OP;
              end
              S_RES: begin
                op_a_next   = result_reg;
                opcode_next = key_opcode(val);
                state_next  = S_OP;
              end
              default: ; // operator while entering op_b is ignored
            endcase
          end
          KEY_EXE: begin
            if (state_reg == S_B) begin
              result_next       = alu_result;
              overflow_next     = alu_overflow;
              result_valid_next = 1'b1;
              state_next        = S_RES;
            end
          end
          KEY_CE: begin
            case (state_reg)
              S_A: begin
                op_a_next  = '0;
                cnt_a_next = '0;
              end
              S_OP, S_B: begin
                op_b_next  = '0;
                cnt_b_next = '0;
                state_next = S_B;
              end
              default: do_clear = 1'b1;
            endcase
          end
          KEY_CLR: do_clear = 1'b1;
          default: ; // invalid codes do nothing
        endcase
      end
    end

    if (do_clear) begin
      state_next        = S_A;
      op_a_next         = '0;
      op_b_next         = '0;
      opcode_next       = OPC_ADD;
      result_next       = '0;
      overflow_next     = 1'b0;
      result_valid_next = 1'b0;
      cnt_a_next        = '0;
      cnt_b_next        = '0;
    end
  end

  // Show the operand being worked on, or the result once computed.
  always_comb begin
    case (state_reg)
      S_B:     display = op_b_reg;
      S_RES:   display = result_reg;
      default: display = op_a_reg;
    endcase
  end

  assign op_a         = op_a_reg;
  assign op_b         = op_b_reg;
  assign opcode       = opcode_reg;
  assign result       = result_reg;
  assign result_valid = result_valid_reg;
  assign overflow     = overflow_reg;
  assign state        = state_reg;

endmodule

// File: tb/tb_calc_entry.sv
// Scoreboard bench for calc_entry: the stimulus process runs an arithmetic
// model and queues the expected outputs of every cycle; a monitor checks them.
module tb_calc_entry;
  import calc_pkg::*;

  logic        clk;
  logic        rst;
  logic        sel;
  logic [4:0]  val;
  logic        dec_mode;
  logic [15:0] op_a, op_b, display, result;
  logic [2:0]  opcode;
  logic        result_valid, overflow;
  logic [1:0]  state;

  calc_entry dut (
    .clk          (clk),
    .rst          (rst),
    .sel          (sel),
    .val          (val),
    .dec_mode     (dec_mode),
    .op_a         (op_a),
    .op_b         (op_b),
    .opcode       (opcode),
    .display      (display),
    .result       (result),
    .result_valid (result_valid),
    .overflow     (overflow),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  st;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  opc;
    logic [15:0] disp;
    logic [15:0] res;
    logic        rv;
    logic        ov;
    logic        keyed;
    logic [4:0]  key;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   running  = 0;

  // Reference model state
  int m_state;          // 0 A, 1 OP, 2 B, 3 RES
  int m_a, m_b, m_res, m_opc, m_ca, m_cb;
  bit m_ov, m_rv;

  task automatic model_reset();
    m_state = 0; m_a = 0; m_b = 0; m_res = 0; m_opc = 0;
    m_ca = 0; m_cb = 0; m_ov = 0; m_rv = 0;
  endtask

  function automatic int op_of(input logic [4:0] k);
    case (k)
      KEY_ADD: return 0;
      KEY_SUB: return 1;
      KEY_MUL: return 2;
      KEY_AND: return 3;
      default: return 4;
    endcase
  endfunction

  task automatic model_exec();
    longint x, y, p;
    x = m_a; y = m_b;
    case (m_opc)
      0: begin p = x + y; m_res = int'(p % 65536); m_ov = (p > 65535); end
      1: begin m_res = int'((x - y + 65536) % 65536); m_ov = (x < y); end
      2: begin p = x * y; m_res = int'(p % 65536); m_ov = (p > 65535); end
      3: begin m_res = m_a & m_b; m_ov = 0; end
      default: begin m_res = m_a | m_b; m_ov = 0; end
    endcase
  endtask

  task automatic model_step(input logic s, input logic [4:0] k, input logic dm, input logic r);
    int d;
    int base;
    m_rv = 0;
    if (r) begin model_reset(); return; end
    if (!s) return;
    base = dm ? 10 : 16;
    if (k < 16) begin
      d = int'(k);
      if (dm && d > 9) return;
      case (m_state)
        0: if (m_ca < 4) begin m_a = (m_a * base + d) % 65536; m_ca++; end
        1: begin m_b = d; m_cb = 1; m_state = 2; end
        2: if (m_cb < 4) begin m_b = (m_b * base + d) % 65536; m_cb++; end
        default: begin m_a = d; m_ca = 1; m_b = 0; m_cb = 0; m_state = 0; end
      endcase
    end else if (k == KEY_ADD || k == KEY_SUB || k == KEY_MUL || k == KEY_AND || k == KEY_OR) begin
      if (m_state == 3) begin m_a = m_res; m_opc = op_of(k); m_state = 1; end
      else if (m_state != 2) begin m_opc = op_of(k); m_state = 1; end
    end else if (k == KEY_EXE) begin
      if (m_state == 2) begin model_exec(); m_rv = 1; m_state = 3; end
    end else if (k == KEY_CE) begin
      if (m_state == 0) begin m_a = 0; m_ca = 0; end
      else if (m_state == 3) model_reset();
      else begin m_b = 0; m_cb = 0; m_state = 2; end
    end else if (k == KEY_CLR) begin
      model_reset();
    end
  endtask

  task automatic push_expected(input logic keyed, input logic [4:0] k);
    exp_t e;
    e.st    = 2'(m_state);
    e.a     = 16'(m_a);
    e.b     = 16'(m_b);
    e.opc   = 3'(m_opc);
    e.disp  = (m_state == 2) ? 16'(m_b) : (m_state == 3) ? 16'(m_res) : 16'(m_a);
    e.res   = 16'(m_res);
    e.rv    = m_rv;
    e.ov    = m_ov;
    e.keyed = keyed;
    e.key   = k;
    exp_q.push_back(e);
    running = 1;
  endtask

  // One clock of stimulus: drive inputs, advance the model, queue the expectation.
  task automatic cycle(input logic s, input logic [4:0] k, input logic dm, input logic r);
    @(negedge clk);
    sel = s; val = k; dec_mode = dm; rst = r;
    model_step(s, k, dm, r);
    push_expected(s | r, k);
  endtask

  task automatic press(input logic [4:0] k, input logic dm);
    cycle(1'b1, k, dm, 1'b0);
    cycle(1'b0, 5'($urandom_range(0, 31)), dm, 1'b0);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents a new output set, compare it to the queue head.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (running) begin
      if (exp_q.size() == 0) begin
        chk("queue_underflow", 16'd1, 16'd0);
      end else begin
        e = exp_q.pop_front();
        chk("state", {14'd0, state}, {14'd0, e.st});
        chk("op_a", op_a, e.a);
        chk("op_b", op_b, e.b);
        chk("opcode", {13'd0, opcode}, {13'd0, e.opc});
        chk("display", display, e.disp);
        chk("result", result, e.res);
        chk("result_valid", {15'd0, result_valid}, {15'd0, e.rv});
        chk("overflow", {15'd0, overflow}, {15'd0, e.ov});
        if (e.keyed)
          $display("txn key=%h rst=%b -> state=%0d op_a=%h op_b=%h opc=%0d disp=%h res=%h rv=%b ov=%b",
                   e.key, rst, state, op_a, op_b, opcode, display, result, result_valid, overflow);
      end
    end
  end

  logic [4:0] ops [5];
  logic       dm_r;

  initial begin
    ops[0] = KEY_ADD; ops[1] = KEY_SUB; ops[2] = KEY_MUL; ops[3] = KEY_AND; ops[4] = KEY_OR;
    rst = 1'b1; sel = 1'b0; val = 5'd0; dec_mode = 1'b0;
    model_reset();

    cycle(1'b0, 5'd0, 1'b0, 1'b1);
    cycle(1'b0, 5'd0, 1'b0, 1'b1);
    cycle(1'b0, 5'd0, 1'b0, 1'b0);

    // Hex 1,2,ADD,3,EXE -> 0x15
    press(5'h1, 0); press(5'h2, 0); press(KEY_ADD, 0); press(5'h3, 0); press(KEY_EXE, 0);
    press(KEY_CLR, 0);
    // Decimal 1,2,A,MUL,1,0,EXE -> 120
    press(5'h1, 1); press(5'h2, 1); press(5'hA, 1); press(KEY_MUL, 1);
    press(5'h1, 1); press(5'h0, 1); press(KEY_EXE, 1);
    press(KEY_CLR, 0);
    // Hex 1,2,3,4,5 -> 0x1234, then CE
    press(5'h1, 0); press(5'h2, 0); press(5'h3, 0); press(5'h4, 0); press(5'h5, 0);
    press(KEY_CE, 0);
    press(KEY_CLR, 0);
    // FFFF + 1 overflows, then chained SUB 5
    press(5'hF, 0); press(5'hF, 0); press(5'hF, 0); press(5'hF, 0);
    press(KEY_ADD, 0); press(5'h1, 0); press(KEY_EXE, 0);
    press(KEY_SUB, 0); press(5'h5, 0); press(KEY_EXE, 0);
    press(KEY_CLR, 0);
    // Operator replacement: 7,ADD,SUB,2,EXE -> 5
    press(5'h7, 0); press(KEY_ADD, 0); press(KEY_SUB, 0); press(5'h2, 0); press(KEY_EXE, 0);
    press(KEY_CLR, 0);
    // Reset colliding with EXE
    press(5'h9, 0); press(KEY_MUL, 0); press(5'h3, 0);
    cycle(1'b1, KEY_EXE, 1'b0, 1'b1);
    cycle(1'b0, 5'd0, 1'b0, 1'b0);
    cycle(1'b0, 5'd0, 1'b0, 1'b0);

    // Randomized key stream
    dm_r = 1'b0;
    for (int i = 0; i < 300; i++) begin
      int r;
      logic [4:0] k;
      r = $urandom_range(0, 99);
      if (r < 55)      k = 5'($urandom_range(0, 15));
      else if (r < 75) k = ops[$urandom_range(0, 4)];
      else if (r < 87) k = KEY_EXE;
      else if (r < 92) k = KEY_CE;
      else if (r < 94) k = KEY_CLR;
      else             k = 5'($urandom_range(24, 31));
      if ($urandom_range(0, 9) == 0) dm_r = ~dm_r;
      if ($urandom_range(0, 99) == 0) begin
        cycle(1'b1, k, dm_r, 1'b1);
        cycle(1'b0, 5'($urandom_range(0, 31)), dm_r, 1'b0);
      end else begin
        press(k, dm_r);
      end
    end

    @(posedge clk);
    #2;
    running = 0;
    chk("queue_drain", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
